// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: writeback select, FUNC3 access
// codes, exception codes and FSM state encoding.
package mem_access_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ALIGN = 2'd1;
    localparam logic [1:0] EXC_BUS   = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Loads accept signed and unsigned sub-word forms; stores only sized ones.
    function automatic logic func3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

endpackage

// File: rtl/mem_access_stage_data_align.sv
// Combinational data alignment: byte enables, store lane replication,
// load byte/half extraction with sign/zero extension, and bad-access detect.
module mem_data_align
    import mem_access_stage_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        bad
);

    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Size decode drives lane enables, store replication and alignment check.
    always_comb begin
        be         = '0;
        wdata      = store_data;
        misaligned = 1'b0;
        unique case (func3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                be         = 4'b1111;
                misaligned = |addr_lo;
            end
            default: begin
                be = '0;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        unique case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        unique case (func3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

    assign bad = (is_load | is_store) & (~func3_legal(is_load, func3) | misaligned);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory request/ack handshake with timeout,
// upstream stall generation and the MEM/WB pipeline register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REG_WRITE_EN_EXMEM,
    input  logic [1:0]  WB_VALUE_SEL_EXMEM,
    input  logic        MEM_READ_EN_EXMEM,
    input  logic        MEM_WRITE_EN_EXMEM,
    input  logic [31:0] PC_EXMEM,
    input  logic [31:0] RESULT_EXMEM,
    input  logic [31:0] REG_DATA_2_EXMEM,
    input  logic [2:0]  FUNC3_EXMEM,
    input  logic [4:0]  REG_WRITE_ADDR_EXMEM,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        MEM_BUSYWAIT,
    output logic        REG_WRITE_EN_MEMWB,
    output logic [1:0]  WB_VALUE_SEL_MEMWB,
    output logic [31:0] PC_MEMWB,
    output logic [31:0] RESULT_MEMWB,
    output logic [31:0] LOAD_DATA_MEMWB,
    output logic [4:0]  REG_WRITE_ADDR_MEMWB,
    output logic [1:0]  EXC_MEMWB
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic        is_load;
    logic        is_store;
    logic        access;
    logic        bad;
    logic        bad_access;
    logic        legal;
    logic        timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;

    // Read wins when both enables are set.
    assign is_load    = MEM_READ_EN_EXMEM;
    assign is_store   = ~MEM_READ_EN_EXMEM & MEM_WRITE_EN_EXMEM;
    assign access     = is_load | is_store;
    assign bad_access = access & bad;
    assign legal      = access & ~bad;

    mem_data_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .func3      (FUNC3_EXMEM),
        .addr_lo    (RESULT_EXMEM[1:0]),
        .store_data (REG_DATA_2_EXMEM),
        .rdata      (DMEM_RDATA),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data),
        .bad        (bad)
    );

    // The stall holds EX/MEM stable, so the request fields stay stable in WAIT.
    assign timeout_hit  = (state == ST_WAIT) & legal & (cnt == TMO_LAST) & ~DMEM_ACK;
    assign DMEM_REQ     = legal;
    assign DMEM_WE      = legal & is_store;
    assign DMEM_BE      = legal ? be : '0;
    assign DMEM_ADDR    = {RESULT_EXMEM[31:2], 2'b00};
    assign DMEM_WDATA   = wdata;
    assign MEM_BUSYWAIT = legal & ~DMEM_ACK & ~timeout_hit;

    // Handshake FSM with wait-cycle counter for bus timeout.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (legal & ~DMEM_ACK)
                        state <= ST_WAIT;
                end
                default: begin
                    if (~legal | DMEM_ACK | timeout_hit)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the finished access.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            REG_WRITE_EN_MEMWB   <= 1'b0;
            WB_VALUE_SEL_MEMWB   <= '0;
            PC_MEMWB             <= '0;
            RESULT_MEMWB         <= '0;
            LOAD_DATA_MEMWB      <= '0;
            REG_WRITE_ADDR_MEMWB <= '0;
            EXC_MEMWB            <= EXC_NONE;
        end else if (MEM_BUSYWAIT) begin
            REG_WRITE_EN_MEMWB <= 1'b0;
            EXC_MEMWB          <= EXC_NONE;
        end else begin
            REG_WRITE_EN_MEMWB   <= REG_WRITE_EN_EXMEM & ~bad_access & ~timeout_hit;
            WB_VALUE_SEL_MEMWB   <= WB_VALUE_SEL_EXMEM;
            PC_MEMWB             <= PC_EXMEM;
            RESULT_MEMWB         <= RESULT_EXMEM;
            REG_WRITE_ADDR_MEMWB <= REG_WRITE_ADDR_EXMEM;
            LOAD_DATA_MEMWB      <= (legal & is_load & ~timeout_hit) ? load_data : '0;
            if (bad_access)
                EXC_MEMWB <= EXC_ALIGN;
            else if (timeout_hit)
                EXC_MEMWB <= EXC_BUS;
            else
                EXC_MEMWB <= EXC_NONE;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a short timeout.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        rwe;
    logic [1:0]  sel;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        rwe_wb;
    logic [1:0]  sel_wb;
    logic [31:0] pc_wb;
    logic [31:0] res_wb;
    logic [31:0] ld_wb;
    logic [4:0]  rd_wb;
    logic [1:0]  exc_wb;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
        .CLK                  (clk),
        .RESET                (reset),
        .REG_WRITE_EN_EXMEM   (rwe),
        .WB_VALUE_SEL_EXMEM   (sel),
        .MEM_READ_EN_EXMEM    (rd_en),
        .MEM_WRITE_EN_EXMEM   (wr_en),
        .PC_EXMEM             (pc),
        .RESULT_EXMEM         (res),
        .REG_DATA_2_EXMEM     (rs2),
        .FUNC3_EXMEM          (f3),
        .REG_WRITE_ADDR_EXMEM (rd),
        .DMEM_REQ             (req),
        .DMEM_WE              (we),
        .DMEM_ADDR            (addr),
        .DMEM_BE              (be),
        .DMEM_WDATA           (wdata),
        .DMEM_RDATA           (rdata),
        .DMEM_ACK             (ack),
        .MEM_BUSYWAIT         (busy),
        .REG_WRITE_EN_MEMWB   (rwe_wb),
        .WB_VALUE_SEL_MEMWB   (sel_wb),
        .PC_MEMWB             (pc_wb),
        .RESULT_MEMWB         (res_wb),
        .LOAD_DATA_MEMWB      (ld_wb),
        .REG_WRITE_ADDR_MEMWB (rd_wb),
        .EXC_MEMWB            (exc_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic set_ins(input logic w, input logic [1:0] s, input logic r, input logic wr,
                           input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f, input logic [4:0] dst);
        rwe = w; sel = s; rd_en = r; wr_en = wr;
        pc = p; res = a; rs2 = d; f3 = f; rd = dst;
    endtask

    task automatic set_nop();
        set_ins(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0);
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, "_rwe"}, rwe_wb, 0);
        chk({tag, "_sel"}, sel_wb, 0);
        chk({tag, "_pc"},  pc_wb, 0);
        chk({tag, "_res"}, res_wb, 0);
        chk({tag, "_ld"},  ld_wb, 0);
        chk({tag, "_rd"},  rd_wb, 0);
        chk({tag, "_exc"}, exc_wb, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ack = 1'b0; rdata = '0;
        set_nop();
        tick(); tick();
        chk_wb_zero("reset");
        chk("reset_req", req, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;

        // SW 0x104, zero-wait ack
        set_ins(1'b0, 2'd0, 1'b0, 1'b1, 32'h100, 32'h104, 32'hDEADBEEF, 3'b010, 5'd0);
        ack = 1'b1;
        mid();
        chk("sw_req", req, 1);
        chk("sw_we", we, 1);
        chk("sw_addr", addr, 32'h104);
        chk("sw_be", be, 4'b1111);
        chk("sw_wdata", wdata, 32'hDEADBEEF);
        chk("sw_busy", busy, 0);
        tick();
        ack = 1'b0; set_nop();
        chk("sw_wb_rwe", rwe_wb, 0);
        chk("sw_wb_pc", pc_wb, 32'h100);
        chk("sw_wb_exc", exc_wb, 0);
        chk("sw_wb_ld", ld_wb, 0);

        // LB 0x103, ack after three stalled cycles
        set_ins(1'b1, 2'd1, 1'b1, 1'b0, 32'h108, 32'h103, 32'h0, 3'b000, 5'd5);
        rdata = 32'h80FF_0000;
        mid();
        chk("lb_req", req, 1);
        chk("lb_we", we, 0);
        chk("lb_be", be, 4'b1000);
        chk("lb_addr", addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) mid();
            chk($sformatf("lb_busy%0d", i), busy, 1);
            tick();
            chk($sformatf("lb_bubble_rwe%0d", i), rwe_wb, 0);
            chk($sformatf("lb_bubble_pc%0d", i), pc_wb, 32'h100);
        end
        ack = 1'b1;
        mid();
        chk("lb_ack_busy", busy, 0);
        chk("lb_ack_req", req, 1);
        tick();
        ack = 1'b0; set_nop();
        chk("lb_wb_rwe", rwe_wb, 1);
        chk("lb_wb_ld", ld_wb, 32'hFFFF_FF80);
        chk("lb_wb_rd", rd_wb, 5);
        chk("lb_wb_sel", sel_wb, 1);
        chk("lb_wb_pc", pc_wb, 32'h108);
        chk("lb_wb_exc", exc_wb, 0);
        mid();
        chk("lb_no_reissue", req, 0);
        tick();

        // LHU 0x102, zero-wait
        set_ins(1'b1, 2'd1, 1'b1, 1'b0, 32'h10C, 32'h102, 32'h0, 3'b101, 5'd6);
        rdata = 32'h8001_1234; ack = 1'b1;
        mid();
        chk("lhu_be", be, 4'b1100);
        chk("lhu_busy", busy, 0);
        tick();
        ack = 1'b0; set_nop();
        chk("lhu_wb_ld", ld_wb, 32'h0000_8001);
        chk("lhu_wb_rwe", rwe_wb, 1);
        chk("lhu_wb_rd", rd_wb, 6);

        // LH 0x100 sign-extends the low half
        set_ins(1'b1, 2'd1, 1'b1, 1'b0, 32'h120, 32'h100, 32'h0, 3'b001, 5'd11);
        rdata = 32'h1234_9ABC; ack = 1'b1;
        mid();
        chk("lh_be", be, 4'b0011);
        tick();
        ack = 1'b0; set_nop();
        chk("lh_wb_ld", ld_wb, 32'hFFFF_9ABC);

        // SB 0x102: single lane, byte replicated
        set_ins(1'b0, 2'd0, 1'b0, 1'b1, 32'h124, 32'h102, 32'h1234_56AB, 3'b000, 5'd0);
        ack = 1'b1;
        mid();
        chk("sb_be", be, 4'b0100);
        chk("sb_wdata", wdata, 32'hABAB_ABAB);
        chk("sb_we", we, 1);
        tick();
        ack = 1'b0;

        // SH 0x102: upper half, half replicated
        set_ins(1'b0, 2'd0, 1'b0, 1'b1, 32'h128, 32'h102, 32'h0000_BEEF, 3'b001, 5'd0);
        ack = 1'b1;
        mid();
        chk("sh_be", be, 4'b1100);
        chk("sh_wdata", wdata, 32'hBEEF_BEEF);
        tick();
        ack = 1'b0; set_nop();

        // LW 0x101 misaligned
        set_ins(1'b1, 2'd1, 1'b1, 1'b0, 32'h110, 32'h101, 32'h0, 3'b010, 5'd7);
        mid();
        chk("lwmis_req", req, 0);
        chk("lwmis_busy", busy, 0);
        tick();
        set_nop();
        chk("lwmis_wb_exc", exc_wb, 1);
        chk("lwmis_wb_rwe", rwe_wb, 0);
        chk("lwmis_wb_ld", ld_wb, 0);
        chk("lwmis_wb_pc", pc_wb, 32'h110);

        // Store with illegal FUNC3 011
        set_ins(1'b0, 2'd0, 1'b0, 1'b1, 32'h12C, 32'h100, 32'h0, 3'b011, 5'd0);
        mid();
        chk("still_req", req, 0);
        tick();
        set_nop();
        chk("still_wb_exc", exc_wb, 1);

        // LW 0x200 with no ack: 8 stalled cycles then bus timeout
        set_ins(1'b1, 2'd1, 1'b1, 1'b0, 32'h114, 32'h200, 32'h0, 3'b010, 5'd8);
        for (int i = 0; i < 8; i++) begin
            mid();
            chk($sformatf("tmo_busy%0d", i), busy, 1);
            tick();
            chk($sformatf("tmo_bubble%0d", i), rwe_wb, 0);
        end
        mid();
        chk("tmo_release", busy, 0);
        tick();
        set_nop(); ack = 1'b1; rdata = 32'h5555_5555;
        chk("tmo_wb_exc", exc_wb, 2);
        chk("tmo_wb_rwe", rwe_wb, 0);
        chk("tmo_wb_ld", ld_wb, 0);
        chk("tmo_wb_pc", pc_wb, 32'h114);
        mid();
        chk("late_ack_busy", busy, 0);
        chk("late_ack_req", req, 0);
        tick();
        ack = 1'b0;
        chk("late_ack_exc", exc_wb, 0);
        chk("late_ack_ld", ld_wb, 0);
        chk("late_ack_rwe", rwe_wb, 0);

        // Reset while waiting abandons the request
        set_ins(1'b1, 2'd1, 1'b1, 1'b0, 32'h118, 32'h300, 32'h0, 3'b010, 5'd9);
        mid();
        chk("rstw_busy0", busy, 1);
        tick();
        mid();
        chk("rstw_busy1", busy, 1);
        tick();
        reset = 1'b1; set_nop();
        tick();
        reset = 1'b0;
        chk("rstw_req", req, 0);
        chk("rstw_busy", busy, 0);
        chk_wb_zero("rstw");

        // Pipeline resumes: zero-wait LW then an ALU op
        set_ins(1'b1, 2'd1, 1'b1, 1'b0, 32'h11C, 32'h400, 32'h0, 3'b010, 5'd10);
        rdata = 32'hCAFE_F00D; ack = 1'b1;
        mid();
        chk("resume_busy", busy, 0);
        tick();
        ack = 1'b0;
        chk("resume_ld", ld_wb, 32'hCAFE_F00D);
        chk("resume_rwe", rwe_wb, 1);
        set_ins(1'b1, 2'd0, 1'b0, 1'b0, 32'h120, 32'h55, 32'h0, 3'b000, 5'd12);
        mid();
        chk("alu_req", req, 0);
        tick();
        set_nop();
        chk("alu_res", res_wb, 32'h55);
        chk("alu_rd", rd_wb, 12);
        chk("alu_ld", ld_wb, 0);
        chk("alu_rwe", rwe_wb, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
